spi_sample_transmitter: RTL and testbench
=========================================

Name: spi_sample_transmitter

Overview:
- SPI master that serialises 16-bit PCM samples onto the same 3-wire link (serial_clk, chip_select, mosi) that spi_receiver consumes.
- Sits on the ADC/sample-source side of the link.
- Accepts parallel samples through a valid/ready handshake and generates its own serial_clk from input_clk.
- Sends each sample as one chip-select-framed word, MSB first.

Parameters:
- DATA_WIDTH, 16: bits per frame.
- CLK_DIV, 4: input_clk cycles per serial_clk period. Must be even and ≥2. HALF = CLK_DIV/2.
- GAP_CYCLES, 4: input_clk cycles chip_select stays high after a frame before the next accept. Must be ≥1.

Ports:
- input_clk, in, 1: system clock (12.288 MHz).
- reset, in, 1: synchronous, active-high reset.
- sample_in, in, DATA_WIDTH: sample to transmit. Captured on accept.
- sample_valid, in, 1: sample_in is valid.
- sample_ready, out, 1: block can accept a sample.
- serial_clk, out, 1: SPI clock. Idles low. Receiver samples on the rising edge.
- chip_select, out, 1: active-low frame enable.
- mosi, out, 1: serial data, MSB first.
- busy, out, 1: high whenever the state is not IDLE.
- frame_done, out, 1: one-cycle pulse when chip_select deasserts.

Behaviour:
- Reset is synchronous: at any rising input_clk edge with reset=1 the block enters IDLE.
  - Reset output values: sample_ready=1, serial_clk=0, chip_select=1, mosi=0, busy=0, frame_done=0.
  - The shift register, divider and bit counter clear.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- Accept:
  - Occurs at edge T when state=IDLE and sample_valid=1; sample_in is latched.
  - sample_ready=0 from T+1 until the return to IDLE.
  - sample_valid while sample_ready=0 is ignored.
  - Changes on sample_in after accept have no effect on the frame in flight.
- SETUP, cycles T+1 .. T+HALF:
  - chip_select=0, serial_clk=0, mosi=bit DATA_WIDTH-1.
- SHIFT:
  - serial_clk toggles every HALF cycles.
  - Rising edge k (k=1..DATA_WIDTH) appears at cycle T+1+(2k-1)·HALF.
  - mosi changes only on the same cycle serial_clk falls, presenting the next lower bit. It is stable for HALF cycles around each rising edge.
  - A 5-bit counter tracks bits. The final falling edge at T+1+2·DATA_WIDTH·HALF moves the FSM to HOLD.
- HOLD: HALF cycles with chip_select=0, serial_clk=0, mosi=0.
- GAP:
  - Entered at cycle T+1+(2·DATA_WIDTH+1)·HALF.
  - chip_select=1 and frame_done=1 on that cycle only.
  - Lasts GAP_CYCLES cycles, then IDLE with sample_ready=1.
  - With defaults: chip_select low T+1..T+66, frame_done at T+67, sample_ready=1 at T+71.
- Throughput: minimum accept-to-accept spacing is 1+(2·DATA_WIDTH+1)·HALF+GAP_CYCLES cycles (71 with defaults). Back-to-back frames never merge; chip_select is high for at least GAP_CYCLES+1 cycles between frames.
- serial_clk toggles only while chip_select=0. There are no glitches: every output is driven directly from a flop.
- Reset mid-frame (any state): the frame is aborted with no partial frame_done. Outputs take reset values at the next edge and the latched sample is discarded.
- The divider counter restarts at 0 on accept, so edge timing is independent of previous frames.

Test Plan:
- Single frame: reset, sample_in=0xA5C3 with valid at T.
  - Capture mosi on each serial_clk rise → 0xA5C3.
  - chip_select low exactly T+1..T+66.
  - 16 rising edges; frame_done single pulse at T+67.
  - sample_ready=1 at T+71.
- Back-to-back: hold valid with 0x8001, then 0x7FFE.
  - Second accept at T+71; chip_select high T+67..T+71.
  - Decoded words are 0x8001 and 0x7FFE, with no extra serial_clk edges in the gap.
- Ignored input: pulse valid with 0x1234 at T+20 and change sample_in during the frame.
  - Transmitted word is unchanged.
  - No second frame starts unless valid is high in IDLE.
- Reset mid-frame: assert reset after the 8th rising edge.
  - Next cycle: chip_select=1, serial_clk=0, mosi=0, sample_ready=1, frame_done never pulsed.
  - A following 0xFFFF frame transmits correctly.
- Extremes: frames 0x0000 and 0xFFFF → mosi constant 0 / 1 during SHIFT; 16 serial_clk rises each.
- Parameter variant CLK_DIV=2, GAP_CYCLES=1: frame 0x5AA5 → chip_select low T+1..T+33, serial_clk period 2 cycles, sample_ready at T+35, decoded word 0x5AA5.

Source files
------------

// File: rtl/spi_sample_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : spi_sample_transmitter
// Description : SPI master that serialises parallel PCM samples onto a
//               3-wire link (serial_clk, chip_select, mosi), MSB first, one
//               chip-select-framed word per sample. serial_clk is derived
//               from input_clk by dividing it by CLK_DIV.
// Ports       : input_clk    - system clock
//               reset        - synchronous, active-high reset
//               sample_in    - sample word, captured on accept
//               sample_valid - sample_in is valid
//               sample_ready - block can accept a sample (high in IDLE)
//               serial_clk   - SPI clock, idles low, receiver samples on rise
//               chip_select  - active-low frame enable
//               mosi         - serial data, MSB first
//               busy         - high whenever the FSM is not IDLE
//               frame_done   - one-cycle pulse as chip_select deasserts
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sample_transmitter #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  input_clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  serial_clk,
  output logic                  chip_select,
  output logic                  mosi,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int MAXC  = (HALF > GAP_CYCLES) ? HALF : GAP_CYCLES;
  // One shared counter times SETUP/SHIFT/HOLD half-periods and the GAP.
  localparam int CW    = $clog2(MAXC + 1);
  localparam int BW    = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

  logic ready_q, ready_d;
  logic sclk_q, sclk_d;
  logic cs_q, cs_d;
  logic mosi_q, mosi_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic half_done;
  logic gap_done;

  assign half_done = (cnt_q == CW'(HALF - 1));
  assign gap_done  = (cnt_q == CW'(GAP_CYCLES - 1));

  // --------------------------------------------------------------------------
  // State and output registers: every output comes straight from a flop.
  // --------------------------------------------------------------------------
  always_ff @(posedge input_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ready_q <= 1'b1;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ready_q <= ready_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          // Divider restarts on every accept so edge timing never depends
          // on the previous frame.
          state_d = ST_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          shreg_d = sample_in;
        end
      end
      ST_SETUP: begin
        if (half_done) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        if (half_done) begin
          cnt_d = '0;
          // sclk_q high here means this half-period ends with a falling edge.
          if (sclk_q) begin
            if (bit_q == BW'(DATA_WIDTH - 1)) begin
              state_d = ST_HOLD;
            end else begin
              bit_d   = bit_q + BW'(1);
              shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (half_done) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: next values of the output flops, derived from the
  // upcoming state so outputs line up with the state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    cs_d    = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
                (state_d == ST_HOLD));
    sclk_d  = 1'b0;
    if (state_d == ST_SHIFT) begin
      if (state_q == ST_SETUP) begin
        sclk_d = 1'b1;              // first rising edge ends SETUP
      end else if (half_done) begin
        sclk_d = ~sclk_q;
      end else begin
        sclk_d = sclk_q;
      end
    end
    // shreg_d MSB is the bit on the wire; it only moves on falling edges.
    mosi_d  = ((state_d == ST_SETUP) || (state_d == ST_SHIFT)) ?
              shreg_d[DATA_WIDTH-1] : 1'b0;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_HOLD) && (state_d == ST_GAP);
  end

  assign sample_ready = ready_q;
  assign serial_clk   = sclk_q;
  assign chip_select  = cs_q;
  assign mosi         = mosi_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_sample_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_sample_transmitter
// Description : Bench for spi_sample_transmitter. Two instances: default
//               parameters (A) and CLK_DIV=2/GAP_CYCLES=1 (B). Expected
//               outputs come from a timeline model indexed by cycles since
//               accept, plus a receiver that decodes mosi on serial_clk rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sample_transmitter;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] a_din, b_din;
  logic          a_val, b_val;
  logic a_rdy, a_sclk, a_cs, a_mosi, a_busy, a_done;
  logic b_rdy, b_sclk, b_cs, b_mosi, b_busy, b_done;

  int checks = 0;
  int errors = 0;

  spi_sample_transmitter #(.DATA_WIDTH(DW), .CLK_DIV(4), .GAP_CYCLES(4)) u_a (
    .input_clk(clk), .reset(rst), .sample_in(a_din), .sample_valid(a_val),
    .sample_ready(a_rdy), .serial_clk(a_sclk), .chip_select(a_cs),
    .mosi(a_mosi), .busy(a_busy), .frame_done(a_done));

  spi_sample_transmitter #(.DATA_WIDTH(DW), .CLK_DIV(2), .GAP_CYCLES(1)) u_b (
    .input_clk(clk), .reset(rst), .sample_in(b_din), .sample_valid(b_val),
    .sample_ready(b_rdy), .serial_clk(b_sclk), .chip_select(b_cs),
    .mosi(b_mosi), .busy(b_busy), .frame_done(b_done));

  // Vector layout: {chip_select, serial_clk, mosi, sample_ready, frame_done, busy}
  localparam logic [5:0] IDLE_VEC = 6'b100100;

  function automatic logic [5:0] obs(input bit sel);
    return sel ? {b_cs, b_sclk, b_mosi, b_rdy, b_done, b_busy}
               : {a_cs, a_sclk, a_mosi, a_rdy, a_done, a_busy};
  endfunction

  // Expected outputs n cycles after the accept edge.
  function automatic logic [5:0] model(input int n, input logic [DW-1:0] w,
                                       input int h, input int g);
    int   len;
    logic cs, sclk, mo, rdy, done, bsy;
    len = (2 * DW + 1) * h;
    cs = 1'b1; sclk = 1'b0; mo = 1'b0; rdy = 1'b1; done = 1'b0; bsy = 1'b0;
    if (n >= 1 && n <= len) begin
      cs = 1'b0; rdy = 1'b0; bsy = 1'b1;
      if (n <= 2 * DW * h) begin
        mo   = w[DW - 1 - ((n - 1) / (2 * h))];
        sclk = (((n - 1) / h) % 2) == 1;
      end
    end else if (n > len && n <= len + g) begin
      rdy = 1'b0; bsy = 1'b1; done = (n == len + 1);
    end
    return {cs, sclk, mo, rdy, done, bsy};
  endfunction

  task automatic chk(input string tag, input int idx,
                     input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, observed, expected);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [DW-1:0] d);
    if (sel) begin b_val = v; b_din = d; end
    else     begin a_val = v; a_din = d; end
  endtask

  // Runs one frame starting from IDLE (called #1 after an edge).
  // Returns #1 after the edge that starts the first IDLE cycle.
  task automatic frame(input bit sel, input logic [DW-1:0] w, input bit noise,
                       input bit keep, input logic [DW-1:0] nxt, input string tag);
    int h, g, len, last, rises;
    logic [DW-1:0] dec;
    logic prev;
    logic [5:0] o;
    h = sel ? 1 : 2;
    g = sel ? 1 : 4;
    len = (2 * DW + 1) * h;
    last = len + g + 1;
    rises = 0; dec = '0; prev = 1'b0;
    drive(sel, 1'b1, w);
    @(posedge clk); #1;
    drive(sel, keep, keep ? nxt : DW'($urandom));
    for (int n = 1; n <= last; n++) begin
      o = obs(sel);
      chk({tag, "_cyc"}, n, 32'(o), 32'(model(n, w, h, g)));
      if (o[4] && !prev) begin
        dec = {dec[DW-2:0], o[3]};
        rises++;
      end
      prev = o[4];
      if (noise && n < len) begin
        if (n == 20)                          drive(sel, 1'b1, 16'h1234);
        else if ($urandom_range(7, 0) == 0)   drive(sel, 1'b1, DW'($urandom));
        else                                  drive(sel, 1'b0, DW'($urandom));
      end else if (!keep) begin
        drive(sel, 1'b0, '0);
      end
      if (n < last) begin @(posedge clk); #1; end
    end
    chk({tag, "_word"}, 0, 32'(dec), 32'(w));
    chk({tag, "_rises"}, 0, 32'(rises), 32'(DW));
  endtask

  initial begin
    logic [DW-1:0] w;
    int dones;
    rst = 1'b1;
    a_val = 1'b0; a_din = '0;
    b_val = 1'b0; b_din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", 0, 32'(obs(1'b0)), 32'(IDLE_VEC));
    chk("reset_b", 0, 32'(obs(1'b1)), 32'(IDLE_VEC));
    rst = 1'b0;
    @(posedge clk); #1;

    // Single frame
    frame(1'b0, 16'hA5C3, 1'b0, 1'b0, '0, "single");

    // Back-to-back with valid held high
    frame(1'b0, 16'h8001, 1'b0, 1'b1, 16'h7FFE, "b2b_1");
    frame(1'b0, 16'h7FFE, 1'b0, 1'b0, '0, "b2b_2");

    // Valid pulses and data changes while busy are ignored
    w = DW'($urandom);
    frame(1'b0, w, 1'b1, 1'b0, '0, "ignored");
    for (int k = 0; k < 6; k++) begin
      chk("no_restart", k, 32'(obs(1'b0)), 32'(IDLE_VEC));
      @(posedge clk); #1;
    end

    // Reset after the 8th rising edge
    w = DW'($urandom);
    dones = 0;
    drive(1'b0, 1'b1, w);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0);
    for (int n = 1; n <= 1 + 15 * 2; n++) begin
      chk("pre_reset", n, 32'(obs(1'b0)), 32'(model(n, w, 2, 4)));
      if (a_done) dones++;
      if (n < 1 + 15 * 2) begin @(posedge clk); #1; end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_reset", 0, 32'(obs(1'b0)), 32'(IDLE_VEC));
    for (int k = 0; k < 80; k++) begin
      if (a_done || !a_cs) dones++;
      @(posedge clk); #1;
    end
    chk("no_partial_done", 0, 32'(dones), 32'(0));
    frame(1'b0, 16'hFFFF, 1'b0, 1'b0, '0, "after_reset");

    // Extremes
    frame(1'b0, 16'h0000, 1'b0, 1'b0, '0, "zeros");
    frame(1'b0, 16'hFFFF, 1'b0, 1'b0, '0, "ones");

    // Randomised frames with input noise
    for (int k = 0; k < 3; k++)
      frame(1'b0, DW'($urandom), 1'b1, 1'b0, '0, "rand_a");

    // Fast variant: CLK_DIV=2, GAP_CYCLES=1
    frame(1'b1, 16'h5AA5, 1'b0, 1'b0, '0, "variant");
    frame(1'b1, DW'($urandom), 1'b0, 1'b1, 16'h3C3C, "var_b2b_1");
    frame(1'b1, 16'h3C3C, 1'b0, 1'b0, '0, "var_b2b_2");
    for (int k = 0; k < 2; k++)
      frame(1'b1, DW'($urandom), 1'b1, 1'b0, '0, "rand_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
